// File: rtl/mem_handshake_unit_pkg.sv
// Shared definitions for the memory handshake unit: FSM state encoding,
// access-size codes and the small per-size helpers used by the datapath.
package mem_handshake_unit_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  // Access size codes on data_type; 2'b11 is reserved and behaves as a word.
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] lsb);
    case (dt)
      DT_BYTE: return 1'b0;
      DT_HALF: return lsb[0];
      default: return lsb != 2'b00;
    endcase
  endfunction

  // Byte-lane write enables; bit 3 is the byte at the access address (MSB).
  function automatic logic [3:0] lane_we(input logic [1:0] dt);
    case (dt)
      DT_BYTE: return 4'b1000;
      DT_HALF: return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // Move right-justified MDR data up to the big-endian lane positions.
  function automatic logic [31:0] align_wdata(input logic [1:0] dt, input logic [31:0] data);
    case (dt)
      DT_BYTE: return {data[7:0], 24'h0};
      DT_HALF: return {data[15:0], 16'h0};
      default: return data;
    endcase
  endfunction

  // Right-justify the leading byte/halfword of a big-endian read and extend it.
  function automatic logic [31:0] extend_rdata(input logic [1:0] dt, input logic sext,
                                               input logic [31:0] rdata);
    case (dt)
      DT_BYTE: return {{24{sext & rdata[31]}}, rdata[31:24]};
      DT_HALF: return {{16{sext & rdata[31]}}, rdata[31:16]};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_handshake_unit_byte_array.sv
// Byte-organised RAM, 2^ADDR_W x 8, with a 32-bit big-endian window starting
// at addr. Lane i covers byte addr+i (wrapping), lane 0 is bits 31:24.
module mem_byte_array
  import mem_handshake_unit_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // NOTE: storage has no reset; clearing a RAM costs a reset tree on every
  // bit and the contents must survive the unit's reset anyway.
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // Per-lane byte addresses; the ADDR_W-bit sum wraps at the top of memory.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + ADDR_W'(i);
    end
  end

  // Asynchronous big-endian read of the four bytes at addr.
  always_comb begin
    rdata = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
             mem_q[lane_addr[2]], mem_q[lane_addr[3]]};
  end

  // Byte-lane writes; we[3-i] enables lane i.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) begin
        mem_q[lane_addr[i]] <= wdata[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/mem_handshake_unit.sv
// Memory side of the MOV/MOC handshake: accepts an operation, waits a fixed
// number of cycles, performs the sized big-endian access and raises MOC until
// the control unit drops MOV.
module mem_handshake_unit
  import mem_handshake_unit_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MOV,
  input  logic        RW,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_type,
  input  logic        sign_ext,
  output logic [31:0] data_out,
  output logic        MOC,
  output logic        busy,
  output logic        misaligned
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        dt_q, dt_d;
  logic              sext_q, sext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              moc_q, moc_d;
  logic              busy_q, busy_d;
  logic              mis_q, mis_d;
  logic [31:0]       dout_q, dout_d;

  // Operands for the access: live inputs while idle (zero-wait accesses
  // complete on the accepting edge), frozen copies afterwards.
  logic [ADDR_W-1:0] op_addr;
  logic              op_rw;
  logic [1:0]        op_dt;
  logic              op_sext;
  logic [31:0]       op_wdata;
  logic              op_mis;
  logic              enter_done;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;

  // Only the low ADDR_W address bits select a byte; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_W];

  mem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (op_addr),
    .wdata (align_wdata(op_dt, op_wdata)),
    .rdata (ram_rdata)
  );

  // Select live or latched operands depending on whether an access is open.
  always_comb begin
    if (state_q == IDLE) begin
      op_addr  = address[ADDR_W-1:0];
      op_rw    = RW;
      op_dt    = data_type;
      op_sext  = sign_ext;
      op_wdata = data_in;
    end else begin
      op_addr  = addr_q;
      op_rw    = rw_q;
      op_dt    = dt_q;
      op_sext  = sext_q;
      op_wdata = wdata_q;
    end
    op_mis = is_misaligned(op_dt, op_addr[1:0]);
  end

  // Next-state, wait counter, operand capture and completion outputs.
  always_comb begin
    // NOTE: every variable gets a hold-value default up front so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    dt_d       = dt_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    moc_d      = moc_q;
    mis_d      = mis_q;
    dout_d     = dout_q;
    enter_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (MOV) begin
          addr_d  = address[ADDR_W-1:0];
          rw_d    = RW;
          dt_d    = data_type;
          sext_d  = sign_ext;
          wdata_d = data_in;
          if (WAIT_STATES == 0) begin
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!MOV) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (!MOV) begin
          state_d = IDLE;
          moc_d   = 1'b0;
          mis_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A misaligned access still completes so the control unit never stalls,
    // but it neither writes memory nor disturbs data_out.
    if (enter_done) begin
      state_d = DONE;
      moc_d   = 1'b1;
      mis_d   = op_mis;
      if (op_rw && !op_mis) begin
        dout_d = extend_rdata(op_dt, op_sext, ram_rdata);
      end
    end

    busy_d = (state_d != IDLE);
    // The RAM has no reset, so block a commit edge that coincides with clr.
    ram_we = (enter_done && !op_rw && !op_mis && clr) ? lane_we(op_dt) : 4'b0000;
  end

  // State and registered outputs; clr returns to IDLE immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      dt_q    <= DT_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      moc_q   <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      moc_q   <= moc_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out   = dout_q;
  assign MOC        = moc_q;
  assign busy       = busy_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Bench for mem_handshake_unit: a two-wait-state and a zero-wait-state build
// side by side, directed scenarios followed by random accesses, all checked
// against a byte-array memory model.
module tb_mem_handshake_unit;

  localparam int ADDR_W    = 9;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        clr  [2];
  logic        mov  [2];
  logic        rw   [2];
  logic        sext [2];
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [1:0]  dt   [2];
  logic [31:0] dout [2];
  logic        moc  [2];
  logic        busy [2];
  logic        mis  [2];

  // Reference state: memory image and expected data_out per DUT.
  logic [7:0]  mem_m [2][MEM_BYTES];
  logic [31:0] exp_dout [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_handshake_unit #(.ADDR_W(ADDR_W), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .clr(clr[0]), .MOV(mov[0]), .RW(rw[0]), .address(addr[0]),
    .data_in(din[0]), .data_type(dt[0]), .sign_ext(sext[0]),
    .data_out(dout[0]), .MOC(moc[0]), .busy(busy[0]), .misaligned(mis[0])
  );

  mem_handshake_unit #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .clr(clr[1]), .MOV(mov[1]), .RW(rw[1]), .address(addr[1]),
    .data_in(din[1]), .data_type(dt[1]), .sign_ext(sext[1]),
    .data_out(dout[1]), .MOC(moc[1]), .busy(busy[1]), .misaligned(mis[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  // Big-endian read of nb bytes, optionally sign-extended to 32 bits.
  function automatic logic [31:0] model_read(input int d, input int a, input int nb, input bit s);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_m[d][(a + i) % MEM_BYTES]);
    if (s && nb < 4 && v >= (32'd1 << (8*nb - 1))) v = v - (32'd1 << (8*nb));
    return v;
  endfunction

  task automatic model_write(input int d, input int a, input int nb, input logic [31:0] wd);
    for (int i = 0; i < nb; i++) mem_m[d][(a + i) % MEM_BYTES] = 8'(wd >> (8*(nb - 1 - i)));
  endtask

  // One complete handshake. Entered and left on a negedge, so back-to-back
  // calls re-raise MOV in the very cycle MOC drops.
  task automatic run_op(input int d, input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] t, input logic s, input string tag);
    int ws   = (d == 0) ? 2 : 0;
    int nb   = size_bytes(t);
    int base = int'(a % MEM_BYTES);
    bit bad  = (base % nb) != 0;
    mov[d] = 1'b1; rw[d] = r; addr[d] = a; din[d] = wd; dt[d] = t; sext[d] = s;
    for (int c = 0; c <= ws; c++) begin
      @(posedge clk); @(negedge clk);
      // Disturb the operand inputs: the unit must use its captured copies.
      addr[d] = $urandom; din[d] = $urandom; dt[d] = 2'($urandom);
      rw[d] = 1'($urandom); sext[d] = 1'($urandom);
      if (c < ws) begin
        check($sformatf("%s moc_wait%0d", tag, c), moc[d], 0);
        check($sformatf("%s busy_wait%0d", tag, c), busy[d], 1);
      end
    end
    if (!bad) begin
      if (r) exp_dout[d] = model_read(d, base, nb, s);
      else model_write(d, base, nb, wd);
    end
    check({tag, " moc"}, moc[d], 1);
    check({tag, " busy"}, busy[d], 1);
    check({tag, " misaligned"}, mis[d], bad);
    check({tag, " data_out"}, dout[d], exp_dout[d]);
    @(posedge clk); @(negedge clk);
    check({tag, " moc_hold"}, moc[d], 1);
    mov[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, " moc_drop"}, moc[d], 0);
    check({tag, " busy_drop"}, busy[d], 0);
    check({tag, " mis_drop"}, mis[d], 0);
    check({tag, " data_hold"}, dout[d], exp_dout[d]);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; mov[d] = 1'b0; rw[d] = 1'b1; sext[d] = 1'b0;
      addr[d] = '0; din[d] = '0; dt[d] = 2'd2; exp_dout[d] = '0;
    end
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d moc", d), moc[d], 0);
      check($sformatf("reset%0d busy", d), busy[d], 0);
      check($sformatf("reset%0d mis", d), mis[d], 0);
      check($sformatf("reset%0d data_out", d), dout[d], 0);
      clr[d] = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check("idle busy", busy[0], 0);

    // Give both memories known contents.
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < MEM_BYTES; a += 4) run_op(d, 1'b0, 32'(a), $urandom, 2'd2, 1'b0, "preload");

    // Directed sequence on the two-wait-state build.
    run_op(0, 1'b0, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "wr_word");
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_word");
    check("tp rd_word", dout[0], 32'hDEADBEEF);
    run_op(0, 1'b1, 32'h11, 32'h0, 2'd0, 1'b0, "rd_byte_z");
    check("tp rd_byte_z", dout[0], 32'h000000AD);
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd0, 1'b1, "rd_byte_s");
    check("tp rd_byte_s", dout[0], 32'hFFFFFFDE);
    run_op(0, 1'b1, 32'h12, 32'h0, 2'd1, 1'b1, "rd_half_s");
    check("tp rd_half_s", dout[0], 32'hFFFFBEEF);
    run_op(0, 1'b0, 32'h12, 32'h55, 2'd0, 1'b0, "wr_byte");
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_after_byte");
    check("tp rd_after_byte", dout[0], 32'hDEAD55EF);
    run_op(0, 1'b0, 32'h10, 32'h1234, 2'd1, 1'b0, "wr_half");
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_after_half");
    check("tp rd_after_half", dout[0], 32'h123455EF);
    run_op(0, 1'b0, 32'h13, 32'hCAFEF00D, 2'd2, 1'b0, "wr_misaligned");
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_after_mis");
    check("tp rd_after_mis", dout[0], 32'h123455EF);

    // Abort: MOV withdrawn after the accepting edge.
    mov[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h10; din[0] = 32'h0; dt[0] = 2'd2;
    @(posedge clk); @(negedge clk);
    check("abort busy_wait", busy[0], 1);
    check("abort moc_wait", moc[0], 0);
    mov[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort moc%0d", c), moc[0], 0);
      check($sformatf("abort busy%0d", c), busy[0], 0);
    end
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_after_abort");
    check("tp rd_after_abort", dout[0], 32'h123455EF);

    // Reset pulse while waiting: outputs clear without a clock edge.
    mov[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h10; din[0] = 32'h0; dt[0] = 2'd2;
    @(posedge clk); @(negedge clk);
    check("rst busy_before", busy[0], 1);
    clr[0] = 1'b0;
    #1;
    check("rst moc", moc[0], 0);
    check("rst busy", busy[0], 0);
    check("rst data_out", dout[0], 0);
    exp_dout[0] = '0;
    mov[0] = 1'b0;
    #1 clr[0] = 1'b1;
    @(negedge clk);
    run_op(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "rd_after_rst");
    check("tp rd_after_rst", dout[0], 32'h123455EF);

    // Zero-wait build: completion on the sampling edge, address aliasing.
    run_op(1, 1'b0, 32'h10, 32'h0BADF00D, 2'd2, 1'b0, "ws0 wr");
    run_op(1, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, "ws0 rd");
    check("tp ws0 rd", dout[1], 32'h0BADF00D);
    run_op(1, 1'b1, 32'h210, 32'h0, 2'd2, 1'b0, "ws0 alias");
    check("tp ws0 alias", dout[1], 32'h0BADF00D);

    // Random accesses, mostly aligned, with random upper address bits.
    for (int n = 0; n < 120; n++) begin
      int d = n % 2;
      logic [1:0]  t = 2'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'(size_bytes(t) - 1);
      run_op(d, 1'($urandom), a, $urandom, t, 1'($urandom), $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
